// File: rtl/wb_reg128_initiator_if.sv
// Pipelined Wishbone B4 bus bundle between the 128-bit register initiator and its slave.
interface wb_reg128_initiator_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic [ADDR_WIDTH-1:0] wb_adr_o;
  logic [3:0]            wb_sel_o;
  logic                  wb_we_o;
  logic [31:0]           wb_dat_o;
  logic [31:0]           wb_dat_i;
  logic                  wb_ack_i;
  logic                  wb_err_i;
  logic                  wb_rty_i;
  logic                  wb_stall_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_adr_o, wb_sel_o, wb_we_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_adr_o, wb_sel_o, wb_we_o, wb_dat_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i
  );
endinterface

// File: rtl/wb_reg128_initiator.sv
// Wishbone B4 pipelined initiator moving one 128-bit value as four 32-bit words, MSW first.
// Defining WB_TIMEOUT_EN adds a per-word ack timeout of TIMEOUT_CYCLES clock cycles.
module wb_reg128_initiator #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] base_adr_i,
  input  logic [127:0]          wr_data_i,
  output logic [127:0]          rd_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  wb_reg128_initiator_if.master wb
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                state;
  logic [1:0]            k;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] base;
  logic [127:0]          wdata;
  logic [95:0]           rdata;
  logic                  listening;
  logic                  step;
  logic                  fail;
  logic                  finish;

`ifdef WB_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TW-1:0] tmo_cnt;
`endif

  function automatic logic [31:0] word_of(input logic [127:0] v, input logic [1:0] idx);
    case (idx)
      2'd0:    word_of = v[127:96];
      2'd1:    word_of = v[95:64];
      2'd2:    word_of = v[63:32];
      default: word_of = v[31:0];
    endcase
  endfunction

  // A termination counts in WAIT, or in REQ when the strobe is accepted on the same edge.
  assign listening = (state == WAIT) || ((state == REQ) && !wb.wb_stall_i);

  always_comb begin
    step = listening && wb.wb_ack_i && !(wb.wb_err_i || wb.wb_rty_i);
    fail = listening && (wb.wb_err_i || wb.wb_rty_i);
`ifdef WB_TIMEOUT_EN
    if (!step && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1))) fail = 1'b1;
`endif
    finish = fail || (step && (k == 2'd3));
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      k           <= '0;
      we_q        <= 1'b0;
      base        <= '0;
      wdata       <= '0;
      rdata       <= '0;
      rd_data_o   <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      wb.wb_cyc_o <= 1'b0;
      wb.wb_stb_o <= 1'b0;
      wb.wb_adr_o <= '0;
      wb.wb_sel_o <= 4'h0;
      wb.wb_we_o  <= 1'b0;
      wb.wb_dat_o <= '0;
`ifdef WB_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_i) begin
            we_q        <= we_i;
            base        <= base_adr_i & ~ADDR_WIDTH'(3);
            wdata       <= wr_data_i;
            k           <= '0;
            busy_o      <= 1'b1;
            wb.wb_cyc_o <= 1'b1;
            wb.wb_stb_o <= 1'b1;
            wb.wb_sel_o <= 4'hF;
            wb.wb_we_o  <= we_i;
            wb.wb_adr_o <= base_adr_i & ~ADDR_WIDTH'(3);
            wb.wb_dat_o <= wr_data_i[127:96];
            state       <= REQ;
`ifdef WB_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
          end
        end
        REQ, WAIT: begin
`ifdef WB_TIMEOUT_EN
          tmo_cnt <= tmo_cnt + 1'b1;
`endif
          if (finish) begin
            state       <= DONE;
            done_o      <= 1'b1;
            err_o       <= fail;
            wb.wb_cyc_o <= 1'b0;
            wb.wb_stb_o <= 1'b0;
            wb.wb_sel_o <= 4'h0;
            wb.wb_we_o  <= 1'b0;
            // The whole read value is published at once, and never after an abort.
            if (!fail && !we_q) rd_data_o <= {rdata, wb.wb_dat_i};
          end else if (step) begin
            if (!we_q) begin
              case (k)
                2'd0:    rdata[95:64] <= wb.wb_dat_i;
                2'd1:    rdata[63:32] <= wb.wb_dat_i;
                default: rdata[31:0]  <= wb.wb_dat_i;
              endcase
            end
            k           <= k + 2'd1;
            state       <= REQ;
            wb.wb_stb_o <= 1'b1;
            wb.wb_sel_o <= 4'hF;
            wb.wb_adr_o <= base + ADDR_WIDTH'({k + 2'd1, 2'b00});
            wb.wb_dat_o <= word_of(wdata, k + 2'd1);
`ifdef WB_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
          end else if ((state == REQ) && !wb.wb_stall_i) begin
            wb.wb_stb_o <= 1'b0;
            wb.wb_sel_o <= 4'h0;
            state       <= WAIT;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          err_o  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_reg128_initiator.sv
// Scoreboard bench for wb_reg128_initiator: a reactive slave checks every accepted strobe,
// and each transfer's result (err, rd_data, latency) is compared when done_o pulses.
module tb_wb_reg128_initiator;
  localparam int AW = 32;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
  } bus_t;

  typedef struct {
    logic         err;
    logic [127:0] rd;
    int           lat;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] base_adr = '0;
  logic [127:0]  wr_data = '0;
  logic [127:0]  rd_data;
  logic          busy;
  logic          done;
  logic          err;

  int vectors = 0;
  int miscompares = 0;

  bus_t bus_q[$];
  res_t res_q[$];

  logic [31:0]  mem[4];
  logic [127:0] exp_rd = '0;
  int  word_cnt = 0;
  bit  pending = 0;
  int  stall_word = -1;
  int  stall_left = 0;
  int  err_word = -1;
  bit  use_rty = 0;
  bit  err_with_ack = 0;
  bit  no_ack = 0;

  always #5 clk = ~clk;

  wb_reg128_initiator_if #(.ADDR_WIDTH(AW)) wb ();

  wb_reg128_initiator #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .we_i(we), .base_adr_i(base_adr),
    .wr_data_i(wr_data), .rd_data_o(rd_data), .busy_o(busy), .done_o(done), .err_o(err),
    .wb(wb)
  );

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Slave acting on the negedge: decides stall/ack for the next posedge.
  always @(negedge clk) begin
    bus_t e;
    wb.wb_ack_i   = 1'b0;
    wb.wb_err_i   = 1'b0;
    wb.wb_rty_i   = 1'b0;
    wb.wb_stall_i = 1'b0;
    wb.wb_dat_i   = 32'hBAD0_0000 | 32'(word_cnt);
    if (!rst_n || !wb.wb_cyc_o) begin
      word_cnt = 0;
      pending  = 0;
    end else if (pending) begin
      pending = 0;
      if (word_cnt == err_word) begin
        if (use_rty) wb.wb_rty_i = 1'b1;
        else         wb.wb_err_i = 1'b1;
        if (err_with_ack) begin
          wb.wb_ack_i = 1'b1;
          wb.wb_dat_i = mem[word_cnt];
        end
      end else if (!no_ack) begin
        wb.wb_ack_i = 1'b1;
        wb.wb_dat_i = mem[word_cnt];
      end
      word_cnt++;
    end else if (wb.wb_stb_o) begin
      checkOutput("strobe_expected", bus_q.size() != 0, 1'b1);
      if (bus_q.size() != 0) begin
        if (word_cnt == stall_word && stall_left > 0) begin
          wb.wb_stall_i = 1'b1;
          stall_left--;
          checkOutput("stall_adr", wb.wb_adr_o, bus_q[0].adr);
          checkOutput("stall_dat", wb.wb_dat_o, bus_q[0].dat);
        end else begin
          e = bus_q.pop_front();
          pending = 1;
          checkOutput("bus_adr", wb.wb_adr_o, e.adr);
          checkOutput("bus_we", wb.wb_we_o, e.we);
          checkOutput("bus_sel", wb.wb_sel_o, 4'hF);
          if (e.we) checkOutput("bus_dat", wb.wb_dat_o, e.dat);
        end
      end
    end
  end

  task automatic pushBus(input bit w, input logic [31:0] b, input logic [127:0] d, input int n);
    bus_t e;
    logic [31:0] ab;
    ab = b & ~32'h3;
    for (int i = 0; i < n; i++) begin
      e.adr = ab + 32'(4 * i);
      e.we  = w;
      e.dat = d[127 - 32 * i -: 32];
      bus_q.push_back(e);
    end
  endtask

  task automatic applyStimulus(input bit w, input logic [31:0] b, input logic [127:0] d,
                               input int sw, input int sn, input int ew, input bit rty, input bit ewa);
    res_t r;
    int nwords;
    int cycles;
    bit got;
    logic [127:0] old_rd;
    @(negedge clk);
    stall_word = sw; stall_left = sn; err_word = ew;
    use_rty = rty; err_with_ack = ewa; no_ack = 0;
    nwords = (ew >= 0 && ew < 4) ? ew + 1 : 4;
    pushBus(w, b, d, nwords);
    old_rd = exp_rd;
    r.err = (ew >= 0 && ew < 4);
    if (!w && !r.err) exp_rd = {mem[0], mem[1], mem[2], mem[3]};
    r.rd  = exp_rd;
    r.lat = 2 + 2 * nwords + ((sw >= 0 && sw < nwords) ? sn : 0);
    res_q.push_back(r);
    req = 1'b1; we = w; base_adr = b; wr_data = d;
    @(negedge clk);
    req = 1'b0; we = ~w; wr_data = {4{$urandom}}; base_adr = $urandom;
    cycles = 2;
    got = 0;
    checkOutput("busy_rise", busy, 1'b1);
    while (!got && cycles < 80) begin
      if (done) got = 1;
      else begin
        checkOutput("rd_hold", rd_data, old_rd);
        req = (cycles == 4);
        @(negedge clk);
        cycles++;
      end
    end
    req = 1'b0;
    checkOutput("done_seen", got, 1'b1);
    r = res_q.pop_front();
    if (got) begin
      checkOutput("latency", cycles, r.lat);
      checkOutput("err", err, r.err);
      checkOutput("rd_data", rd_data, r.rd);
      checkOutput("cyc_at_done", wb.wb_cyc_o, 1'b0);
    end
    @(negedge clk);
    checkOutput("done_pulse", done, 1'b0);
    checkOutput("busy_fall", busy, 1'b0);
    checkOutput("bus_q_empty", bus_q.size(), 0);
    bus_q.delete();
  endtask

  initial begin
    logic [127:0] d;
    int cycles;
    bit got;
    bit saw_done;

    repeat (2) @(negedge clk);
    checkOutput("rst_cyc", wb.wb_cyc_o, 1'b0);
    checkOutput("rst_stb", wb.wb_stb_o, 1'b0);
    checkOutput("rst_sel", wb.wb_sel_o, 4'h0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_err", err, 1'b0);
    checkOutput("rst_rd", rd_data, 128'h0);
    rst_n = 1'b1;

    applyStimulus(1'b1, 32'h40, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, -1, 0, -1, 0, 0);

    mem = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
    applyStimulus(1'b0, 32'h100, '0, -1, 0, -1, 0, 0);

    d = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(1'b1, 32'h200, d, 2, 3, -1, 0, 0);

    mem = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    applyStimulus(1'b0, 32'h300, '0, -1, 0, 1, 0, 1);
    applyStimulus(1'b0, 32'h300, '0, 1, 2, 3, 1, 0);

    mem = '{32'h5555_AAAA, 32'h6666_BBBB, 32'h7777_CCCC, 32'h8888_DDDD};
    applyStimulus(1'b0, 32'hFFFF_FFFB, '0, -1, 0, -1, 0, 0);

    for (int i = 0; i < 4; i++) begin
      mem = '{$urandom, $urandom, $urandom, $urandom};
      d = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(1'(i), $urandom, d, $urandom_range(0, 3), $urandom_range(0, 2), -1, 0, 0);
    end

    // Reset during word 2 of a read.
    @(negedge clk);
    stall_word = -1; err_word = -1; no_ack = 0;
    mem = '{32'h0BAD_0000, 32'h0BAD_0001, 32'h0BAD_0002, 32'h0BAD_0003};
    pushBus(1'b0, 32'h500, '0, 4);
    req = 1'b1; we = 1'b0; base_adr = 32'h500;
    @(negedge clk);
    req = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (wb.wb_stb_o && word_cnt == 2) got = 1;
    end
    checkOutput("reach_word2", got, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_cyc", wb.wb_cyc_o, 1'b0);
    checkOutput("arst_stb", wb.wb_stb_o, 1'b0);
    checkOutput("arst_busy", busy, 1'b0);
    checkOutput("arst_rd", rd_data, 128'h0);
    saw_done = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    checkOutput("arst_no_done", saw_done, 1'b0);
    bus_q.delete();
    exp_rd = '0;

    mem = '{32'hFACE_0000, 32'hFACE_1111, 32'hFACE_2222, 32'hFACE_3333};
    applyStimulus(1'b0, 32'h600, '0, -1, 0, -1, 0, 0);

    // Slave accepts the first strobe and never acknowledges.
    @(negedge clk);
    stall_word = -1; err_word = -1; no_ack = 1;
    pushBus(1'b1, 32'h700, 128'h0, 1);
    req = 1'b1; we = 1'b1; base_adr = 32'h700; wr_data = '0;
    @(negedge clk);
    req = 1'b0;
    cycles = 2;
`ifdef WB_TIMEOUT_EN
    got = 0;
    while (!got && cycles < 60) begin
      if (done) got = 1;
      else begin
        @(negedge clk);
        cycles++;
      end
    end
    checkOutput("tmo_done", got, 1'b1);
    checkOutput("tmo_latency", cycles, 18);
    checkOutput("tmo_err", err, 1'b1);
`else
    saw_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    checkOutput("hang_busy", busy, 1'b1);
    checkOutput("hang_cyc", wb.wb_cyc_o, 1'b1);
    checkOutput("hang_no_done", saw_done, 1'b0);
`endif
    checkOutput("hang_bus_q", bus_q.size(), 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    no_ack = 0;
    bus_q.delete();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
